// File: rtl/pc_redirect_control.sv
// Fetch PC sequencer: +4 per unstalled cycle, 1-cycle redirect, FLUSH_CYCLES-long IF/ID + ID/EX kill.
// Redirects seen under stall_in park in a pending register until the stall lifts; wrong-path requests are dropped.
module pc_redirect_control #(
  parameter int unsigned         PC_WIDTH     = 20,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int unsigned         FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_in,
  input  logic                select_new_pc_in,
  input  logic [PC_WIDTH-1:0] new_pc_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                fetch_en_out,
  output logic                flush_if_id_out,
  output logic                flush_id_ex_out,
  output logic                busy_out,
  output logic                align_err_out
);

  typedef enum logic [1:0] {RUN, PEND, FLUSH} state_e;

  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
  localparam logic [3:0]          FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;
  logic                pend_mis_q, pend_mis_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic                busy_q, busy_d;
  logic                align_q, align_d;

  logic [PC_WIDTH-1:0] target;
  logic                misalign;

  assign target   = {new_pc_in[PC_WIDTH-1:2], 2'b00};
  assign misalign = |new_pc_in[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_mis_d = pend_mis_q;
    cnt_d      = cnt_q;
    align_d    = 1'b0;
    case (state_q)
      RUN: begin
        if (select_new_pc_in) begin
          if (stall_in) begin
            pend_d     = target;
            pend_mis_d = misalign;
            state_d    = PEND;
          end else begin
            pc_d    = target;
            cnt_d   = FLUSH_LOAD;
            align_d = misalign;
            state_d = FLUSH;
          end
        end else if (!stall_in) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      PEND: begin
        if (!stall_in) begin
          pc_d    = pend_q;
          cnt_d   = FLUSH_LOAD;
          align_d = pend_mis_q;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Flush length is time-based; a stall only freezes the PC, not the count.
        if (!stall_in) begin
          pc_d = pc_q + PC_STEP;
        end
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
    flush_d = (state_d == FLUSH);
    busy_d  = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      pend_mis_q <= 1'b0;
      cnt_q      <= 4'd0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      align_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_mis_q <= pend_mis_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      busy_q     <= busy_d;
      align_q    <= align_d;
    end
  end

  assign pc_out          = pc_q;
  assign fetch_en_out    = ((state_q == RUN) || (state_q == FLUSH)) && !stall_in;
  assign flush_if_id_out = flush_q;
  assign flush_id_ex_out = flush_q;
  assign busy_out        = busy_q;
  assign align_err_out   = align_q;

endmodule

// File: tb/tb_pc_redirect_control.sv
// Directed bench for pc_redirect_control with a per-cycle reference model and literal checkpoints.
module tb_pc_redirect_control;

  localparam int PW = 20;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_in = 1'b0;
  logic          select_new_pc_in = 1'b0;
  logic [PW-1:0] new_pc_in = '0;
  logic [PW-1:0] pc_out;
  logic          fetch_en_out, flush_if_id_out, flush_id_ex_out, busy_out, align_err_out;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  pc_redirect_control #(.PC_WIDTH(PW), .RESET_PC('0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .select_new_pc_in(select_new_pc_in), .new_pc_in(new_pc_in),
    .pc_out(pc_out), .fetch_en_out(fetch_en_out),
    .flush_if_id_out(flush_if_id_out), .flush_id_ex_out(flush_id_ex_out),
    .busy_out(busy_out), .align_err_out(align_err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a fetch address, an optional parked target, and a count of flush cycles left.
  int unsigned   m_pc = 0;
  bit            m_pend = 1'b0;
  int unsigned   m_pend_pc = 0;
  bit            m_pend_mis = 1'b0;
  int            m_flush_left = 0;
  bit            m_align = 1'b0;
  localparam int unsigned PC_MOD = 1 << PW;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_pend = 0; m_pend_pc = 0; m_pend_mis = 0; m_flush_left = 0; m_align = 0;
    end else begin
      m_align = 0;
      if (m_flush_left > 0) begin
        if (!stall_in) m_pc = (m_pc + 4) % PC_MOD;
        m_flush_left--;
      end else if (m_pend) begin
        if (!stall_in) begin
          m_pc = m_pend_pc; m_pend = 0; m_flush_left = FC; m_align = m_pend_mis;
        end
      end else if (select_new_pc_in) begin
        if (stall_in) begin
          m_pend = 1; m_pend_pc = int'(new_pc_in) & ~3; m_pend_mis = (new_pc_in % 4) != 0;
        end else begin
          m_pc = int'(new_pc_in) & ~3; m_flush_left = FC; m_align = (new_pc_in % 4) != 0;
        end
      end else if (!stall_in) begin
        m_pc = (m_pc + 4) % PC_MOD;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pc", 32'(pc_out), m_pc);
      chk("model_flush_if_id", 32'(flush_if_id_out), 32'(m_flush_left > 0));
      chk("model_flush_id_ex", 32'(flush_id_ex_out), 32'(m_flush_left > 0));
      chk("model_busy", 32'(busy_out), 32'(m_pend || (m_flush_left > 0)));
      chk("model_align", 32'(align_err_out), 32'(m_align));
      chk("model_fetch_en", 32'(fetch_en_out), 32'(!m_pend && !stall_in));
    end
  end

  // Drive inputs for the next edge, then wait just past it.
  task automatic step(input logic st, input logic sel, input logic [PW-1:0] npc);
    stall_in = st; select_new_pc_in = sel; new_pc_in = npc;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0; #2; rst_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("reset_pc", 32'(pc_out), 32'h0);
    chk("reset_flush", 32'({flush_if_id_out, flush_id_ex_out}), 32'h0);
    chk("reset_busy", 32'(busy_out), 32'h0);
    chk("reset_align", 32'(align_err_out), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Sequential fetch
    step(0, 0, '0); chk("seq_pc1", 32'(pc_out), 32'h4);
    step(0, 0, '0); step(0, 0, '0);
    step(0, 0, '0); chk("seq_pc4", 32'(pc_out), 32'h10);
    chk("seq_noflush", 32'(flush_if_id_out), 32'h0);

    // Unstalled redirect from pc=8
    pulse_reset();
    step(0, 0, '0); step(0, 0, '0); chk("redir_start", 32'(pc_out), 32'h8);
    step(0, 1, 20'h00100); chk("redir_pc", 32'(pc_out), 32'h100);
    chk("redir_flush1", 32'(flush_if_id_out), 32'h1);
    step(0, 0, '0); chk("redir_pc2", 32'(pc_out), 32'h104);
    chk("redir_flush2", 32'(flush_id_ex_out), 32'h1);
    step(0, 0, '0); chk("redir_pc3", 32'(pc_out), 32'h108);
    chk("redir_flush_end", 32'(flush_if_id_out), 32'h0);

    // Stalled redirect; new target during PEND must be ignored
    step(1, 1, 20'h00040); chk("pend_busy", 32'(busy_out), 32'h1);
    chk("pend_hold", 32'(pc_out), 32'h108);
    step(1, 1, 20'h00999); step(1, 1, 20'h00777);
    chk("pend_hold3", 32'(pc_out), 32'h108);
    step(0, 0, '0); chk("pend_load", 32'(pc_out), 32'h40);
    step(0, 0, '0); chk("pend_pc2", 32'(pc_out), 32'h44);
    step(0, 0, '0); chk("pend_done_busy", 32'(busy_out), 32'h0);

    // Wrong-path request during FLUSH
    step(0, 1, 20'h00200); chk("wp_first", 32'(pc_out), 32'h200);
    step(0, 1, 20'h00080); chk("wp_ignored", 32'(pc_out), 32'h204);
    step(0, 1, 20'h00080); chk("wp_ignored2", 32'(pc_out), 32'h208);
    chk("wp_run", 32'(busy_out), 32'h0);
    step(0, 0, '0);

    // Stall during FLUSH: PC freezes, flush still ends on time
    step(0, 1, 20'h00300); step(1, 0, '0);
    chk("fstall_hold", 32'(pc_out), 32'h300);
    step(1, 0, '0); chk("fstall_end", 32'(flush_if_id_out), 32'h0);
    step(0, 0, '0); chk("fstall_resume", 32'(pc_out), 32'h304);

    // Misaligned all-ones target and wrap
    step(0, 1, 20'hFFFFF); chk("wrap_pc", 32'(pc_out), 32'hFFFFC);
    chk("wrap_align", 32'(align_err_out), 32'h1);
    step(0, 0, '0); chk("wrap_zero", 32'(pc_out), 32'h0);
    chk("wrap_align_once", 32'(align_err_out), 32'h0);
    step(0, 0, '0);

    // Misaligned target via the pending path
    step(1, 1, 20'h00013); step(0, 0, '0);
    chk("pend_mis_pc", 32'(pc_out), 32'h10);
    chk("pend_mis_align", 32'(align_err_out), 32'h1);
    step(0, 0, '0); step(0, 0, '0);

    // Reset mid-flush (second flush cycle)
    step(0, 1, 20'h00500); step(0, 0, '0);
    chk("mid_flush_active", 32'(flush_if_id_out), 32'h1);
    #2; rst_n = 1'b0; #1;
    chk("arst_pc", 32'(pc_out), 32'h0);
    chk("arst_flush", 32'({flush_if_id_out, flush_id_ex_out}), 32'h0);
    chk("arst_busy", 32'(busy_out), 32'h0);
    chk("arst_align", 32'(align_err_out), 32'h0);
    #3; rst_n = 1'b1;
    chk("post_rst_pc", 32'(pc_out), 32'h0);
    step(0, 0, '0); chk("post_rst_inc", 32'(pc_out), 32'h4);
    chk("post_rst_noflush", 32'(flush_if_id_out), 32'h0);
    step(0, 0, '0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
